// File: rtl/maxpool_unit.sv
// maxpool_unit: streaming 2x2, stride-2 max-pooling stage.
//
// Consumes a raster-order feature-map stream, one pixel per valid cycle, and
// emits the pooled map in raster order. A half-row line buffer holds the
// horizontal maxima of each even row until the matching odd row arrives, so
// no full-frame storage is needed. Odd INPUT_SIZE uses floor semantics: the
// trailing column and row are consumed but never produce output.
//
// Parameters:
//   N           pixel data width
//   INPUT_SIZE  input map width = height (>= 2); output size is INPUT_SIZE/2
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   ce        clock enable; low freezes all state and ignores din_vld
//   clr       synchronous frame abort; zeroes counters and outputs
//   din_vld   input pixel valid
//   din       input pixel
//   dout      pooled pixel (holds until the next output)
//   dout_vld  one-cycle pulse per pooled pixel
//   dout_end  one-cycle pulse with the last pooled pixel of a frame
//
// Build option:
//   MAXPOOL_SIGNED_EN  when defined, pixels compare as N-bit two's complement;
//                      otherwise comparison is unsigned.

module maxpool_unit #(
    parameter int unsigned N          = 8,
    parameter int unsigned INPUT_SIZE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         clr,
    input  logic         din_vld,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         dout_vld,
    output logic         dout_end
);

    localparam int unsigned OUT_SIZE = INPUT_SIZE / 2;
    localparam int unsigned CW       = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
    localparam int unsigned IW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(INPUT_SIZE - 1);
    localparam logic [CW-1:0] LAST_POOL = CW'(2 * OUT_SIZE - 1);

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [N-1:0]  hreg;
    logic [N-1:0]  lbuf [OUT_SIZE];

    logic          accept;
    logic          col_odd;
    logic          row_odd;
    logic          last_col;
    logic          last_row;
    logic          is_end;
    logic [IW-1:0] lb_idx;
    logic [N-1:0]  hmax;
    logic [N-1:0]  pool;

    function automatic logic [N-1:0] pick_max(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    always_comb begin
        accept   = ce && din_vld && !clr;
        col_odd  = col[0];
        row_odd  = row[0];
        last_col = (col == LAST_IDX);
        last_row = (row == LAST_IDX);
        // Odd col never exceeds 2*OUT_SIZE-1, so col>>1 always fits the buffer.
        lb_idx   = IW'(col >> 1);
        hmax     = pick_max(hreg, din);
        pool     = pick_max(lbuf[lb_idx], hmax);
        is_end   = (row == LAST_POOL) && (col == LAST_POOL);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_end <= 1'b0;
        end else if (ce) begin
            if (clr) begin
                row      <= '0;
                col      <= '0;
                dout     <= '0;
                dout_vld <= 1'b0;
                dout_end <= 1'b0;
            end else begin
                dout_vld <= 1'b0;
                dout_end <= 1'b0;
                if (din_vld) begin
                    // Bottom-right pixel of a window: odd row, odd col.
                    if (col_odd && row_odd) begin
                        dout     <= pool;
                        dout_vld <= 1'b1;
                        dout_end <= is_end;
                    end
                    if (last_col) begin
                        col <= '0;
                        row <= last_row ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    // Datapath storage; contents after reset are irrelevant because every
    // frame writes before it reads.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!col_odd) begin
                hreg <= din;
            end else if (!row_odd) begin
                lbuf[lb_idx] <= hmax;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_unit.sv
// Bench for maxpool_unit: three instances (INPUT_SIZE 4, 5, 2) share ce/clr/din
// and have separate din_vld. A frame-level model stores the accepted pixels of
// each frame and derives every pooled value directly from its 2x2 window.

module tb_maxpool_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       clr;
    logic [2:0] vld;
    logic [7:0] din;

    logic [7:0] dq   [3];
    logic       dvld [3];
    logic       dend [3];

    always #5 clk = ~clk;

    maxpool_unit #(.N(8), .INPUT_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .din_vld(vld[0]), .din(din),
        .dout(dq[0]), .dout_vld(dvld[0]), .dout_end(dend[0])
    );
    maxpool_unit #(.N(8), .INPUT_SIZE(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .din_vld(vld[1]), .din(din),
        .dout(dq[1]), .dout_vld(dvld[1]), .dout_end(dend[1])
    );
    maxpool_unit #(.N(8), .INPUT_SIZE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .din_vld(vld[2]), .din(din),
        .dout(dq[2]), .dout_vld(dvld[2]), .dout_end(dend[2])
    );

    int         sz [3] = '{4, 5, 2};
    int         k  [3];
    logic [7:0] pix [3][25];
    logic [7:0] m_d [3];
    logic       m_v [3];
    logic       m_e [3];
    int         obs [3][$];
    int         ends [3];
    int         eq [$];
    int         n_assert = 0;
    int         n_fail = 0;

    function automatic int sval(input logic [7:0] x);
`ifdef MAXPOOL_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [7:0] pmax4(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] m;
        m = a;
        if (sval(b) > sval(m)) m = b;
        if (sval(c) > sval(m)) m = c;
        if (sval(d) > sval(m)) m = d;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            k[i]   = 0;
            m_d[i] = '0;
            m_v[i] = 1'b0;
            m_e[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dout[S=%0d]", sz[i]), 32'(dq[i]), 32'(m_d[i]));
            chk($sformatf("dout_vld[S=%0d]", sz[i]), 32'(dvld[i]), 32'(m_v[i]));
            chk($sformatf("dout_end[S=%0d]", sz[i]), 32'(dend[i]), 32'(m_e[i]));
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) begin
            obs[i].delete();
            ends[i] = 0;
        end
    endtask

    // One clock: drive, advance, update the frame model, compare every output.
    task automatic step(input logic ce_v, input logic clr_v, input logic [2:0] vld_v,
                        input logic [7:0] d);
        ce  = ce_v;
        clr = clr_v;
        vld = vld_v;
        din = d;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            int s, os, r, c;
            s  = sz[i];
            os = s / 2;
            if (ce_v) begin
                if (clr_v) begin
                    k[i]   = 0;
                    m_d[i] = '0;
                    m_v[i] = 1'b0;
                    m_e[i] = 1'b0;
                end else begin
                    m_v[i] = 1'b0;
                    m_e[i] = 1'b0;
                    if (vld_v[i]) begin
                        pix[i][k[i]] = d;
                        r = k[i] / s;
                        c = k[i] % s;
                        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * os) && (c < 2 * os)) begin
                            m_d[i] = pmax4(pix[i][(r - 1) * s + c - 1], pix[i][(r - 1) * s + c],
                                           pix[i][r * s + c - 1], pix[i][r * s + c]);
                            m_v[i] = 1'b1;
                            m_e[i] = (r == 2 * os - 1) && (c == 2 * os - 1);
                        end
                        k[i] = (k[i] + 1) % (s * s);
                    end
                end
            end
            if (ce_v && !clr_v && dvld[i]) begin
                obs[i].push_back(int'(dq[i]));
                if (dend[i]) ends[i]++;
            end
        end
        check_all();
    endtask

    task automatic send(input logic [2:0] mask, input logic [7:0] d, input int maxgap,
                        input bit ce_drop);
        int gaps;
        gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        for (int g = 0; g < gaps; g++) step(1'b1, 1'b0, 3'b000, 8'h00);
        if (ce_drop && ($urandom_range(0, 3) == 0)) step(1'b0, 1'b0, mask, d);
        step(1'b1, 1'b0, mask, d);
    endtask

    task automatic frame(input int sel, input bit up, input int maxgap);
        int n;
        n = sz[sel] * sz[sel];
        for (int p = 0; p < n; p++) send(3'(1 << sel), 8'(up ? p : n - 1 - p), maxgap, 1'b0);
    endtask

    task automatic chk_obs(input int sel, input int want [$]);
        chk($sformatf("count[S=%0d]", sz[sel]), 32'(obs[sel].size()), 32'(want.size()));
        for (int j = 0; j < want.size() && j < obs[sel].size(); j++)
            chk($sformatf("seq[S=%0d][%0d]", sz[sel], j), 32'(obs[sel][j]), 32'(want[j]));
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        clr   = 1'b0;
        vld   = 3'b000;
        din   = 8'h00;
        model_reset();
        clear_obs();
        #12;
        check_all();
        rst_n = 1'b1;

        // Back-to-back 0..15 frame.
        frame(0, 1'b1, 0);
        step(1'b1, 1'b0, 3'b000, 8'h00);
        eq = '{5, 7, 13, 15};
        chk_obs(0, eq);
        chk("ends_frame1", 32'(ends[0]), 32'd1);

        // Gapped up frame followed directly by a gapped down frame.
        clear_obs();
        frame(0, 1'b1, 3);
        frame(0, 1'b0, 3);
        step(1'b1, 1'b0, 3'b000, 8'h00);
        eq = '{5, 7, 13, 15, 15, 13, 7, 5};
        chk_obs(0, eq);
        chk("ends_two_frames", 32'(ends[0]), 32'd2);

        // Odd size: two consecutive 0..24 frames.
        clear_obs();
        frame(1, 1'b1, 0);
        frame(1, 1'b1, 1);
        step(1'b1, 1'b0, 3'b000, 8'h00);
        eq = '{6, 8, 16, 18, 6, 8, 16, 18};
        chk_obs(1, eq);
        chk("ends_s5", 32'(ends[1]), 32'd2);

        // Signedness window at size 2.
        send(3'b100, 8'hFF, 0, 1'b0);
        send(3'b100, 8'h01, 0, 1'b0);
        send(3'b100, 8'h80, 0, 1'b0);
        send(3'b100, 8'h7F, 0, 1'b0);
`ifdef MAXPOOL_SIGNED_EN
        chk("window_signed", 32'(dq[2]), 32'h7F);
`else
        chk("window_unsigned", 32'(dq[2]), 32'hFF);
`endif
        chk("window_end", 32'(dend[2]), 32'd1);

        // ce drops: once while an output pulse is held, once over an accepting edge.
        clear_obs();
        for (int p = 0; p < 16; p++) begin
            if (p == 6 || p == 13) begin
                for (int h = 0; h < 3; h++) step(1'b0, 1'b0, 3'b001, 8'(p));
            end
            step(1'b1, 1'b0, 3'b001, 8'(p));
        end
        step(1'b1, 1'b0, 3'b000, 8'h00);
        eq = '{5, 7, 13, 15};
        chk_obs(0, eq);

        // clr after pixel 9, with a pixel presented on the clr cycle.
        for (int p = 0; p < 10; p++) step(1'b1, 1'b0, 3'b001, 8'(p));
        step(1'b1, 1'b1, 3'b001, 8'hAA);
        clear_obs();
        frame(0, 1'b1, 0);
        step(1'b1, 1'b0, 3'b000, 8'h00);
        eq = '{5, 7, 13, 15};
        chk_obs(0, eq);

        // Random values into all three instances, with gaps and ce drops.
        for (int p = 0; p < 150; p++) send(3'b111, 8'($urandom), 2, 1'b1);
        for (int p = 0; p < 60; p++) send(3'b011, 8'($urandom), 1, 1'b1);

        // Asynchronous reset mid-frame.
        for (int p = 0; p < 7; p++) step(1'b1, 1'b0, 3'b111, 8'(p + 40));
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_dout[S=%0d]", sz[i]), 32'(dq[i]), 32'd0);
            chk($sformatf("rst_vld[S=%0d]", sz[i]), 32'(dvld[i]), 32'd0);
            chk($sformatf("rst_end[S=%0d]", sz[i]), 32'(dend[i]), 32'd0);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        clear_obs();
        frame(0, 1'b1, 0);
        step(1'b1, 1'b0, 3'b000, 8'h00);
        eq = '{5, 7, 13, 15};
        chk_obs(0, eq);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
